inst_buffer: RTL and testbench

- Decoupling queue between the fetch stage and dispatch.
- Accepts up to SUPERSCALAR_WAYS in-order FETCH_DISPATCH_PACKETs per cycle.
- Holds them in a circular FIFO and presents the oldest SUPERSCALAR_WAYS entries to dispatch.
- Generates the DISPATCH_FETCH_PACKET stall feedback (enable, first_stall_idx) that tells fetch where to resume when not every fetched way was accepted.

---
 rtl/inst_buffer.sv | 134 +++++++++++++
 tb/tb_inst_buffer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/inst_buffer.sv
// inst_buffer: circular decoupling queue between fetch and dispatch.
//   clock              - system clock
//   reset              - synchronous, active-high; clears pointers, count and storage
//   branch_flush_en    - mispredict flush; empties the buffer on the next edge
//   fetch_dispatch_in  - up to SUPERSCALAR_WAYS in-order fetched packets, way 0 oldest
//   dispatch_num       - entries dispatch consumed from the head this cycle
//   dispatch_fetch_out - {enable, first_stall_idx}: where fetch must resume
//   ib_out             - oldest SUPERSCALAR_WAYS entries, ib_out[0] = head
//   ib_count           - registered occupancy

package inst_buffer_pkg;
    localparam int unsigned XLEN             = 32;
    localparam int unsigned SUPERSCALAR_WAYS = 2;
    localparam int unsigned IDX_W            = (SUPERSCALAR_WAYS > 1) ? $clog2(SUPERSCALAR_WAYS) : 1;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] PC;
        logic [XLEN-1:0] NPC;
        logic [XLEN-1:0] inst;
    } FETCH_DISPATCH_PACKET;

    typedef struct packed {
        logic             enable;
        logic [IDX_W-1:0] first_stall_idx;
    } DISPATCH_FETCH_PACKET;
endpackage

// The packet types fix the way count and XLEN; SUPERSCALAR_WAYS must match the package value.
module inst_buffer #(
    parameter int unsigned SUPERSCALAR_WAYS = inst_buffer_pkg::SUPERSCALAR_WAYS,
    parameter int unsigned IB_DEPTH         = 8
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  branch_flush_en,
    input  inst_buffer_pkg::FETCH_DISPATCH_PACKET fetch_dispatch_in [SUPERSCALAR_WAYS],
    input  logic [$clog2(SUPERSCALAR_WAYS+1)-1:0] dispatch_num,
    output inst_buffer_pkg::DISPATCH_FETCH_PACKET dispatch_fetch_out,
    output inst_buffer_pkg::FETCH_DISPATCH_PACKET ib_out [SUPERSCALAR_WAYS],
    output logic [$clog2(IB_DEPTH+1)-1:0]         ib_count
);

    localparam int unsigned PTR_W = $clog2(IB_DEPTH);
    localparam int unsigned CNT_W = $clog2(IB_DEPTH + 1);
    localparam int unsigned IDX_W = inst_buffer_pkg::IDX_W;

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    inst_buffer_pkg::FETCH_DISPATCH_PACKET [IB_DEPTH-1:0] r_mem;

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_lead;
    logic [CNT_W-1:0] w_nvalid;
    logic [CNT_W-1:0] w_k;
    logic [CNT_W-1:0] w_dn;
    logic [CNT_W-1:0] w_d;
    logic             w_stop;
    logic             w_block;

    assign w_block = reset | branch_flush_en;

    // Accept count k: leading valid ways, limited by free space from the registered count only.
    always_comb begin : accept_calc
        w_free   = CNT_W'(IB_DEPTH) - r_count;
        w_lead   = '0;
        w_nvalid = '0;
        w_stop   = 1'b0;
        for (int i = 0; i < int'(SUPERSCALAR_WAYS); i++) begin
            if (fetch_dispatch_in[i].valid) begin
                w_nvalid = w_nvalid + CNT_W'(1);
                if (!w_stop) begin
                    w_lead = w_lead + CNT_W'(1);
                end
            end else begin
                w_stop = 1'b1;
            end
        end
        w_k = (w_lead < w_free) ? w_lead : w_free;
    end

    // Dequeue count d: clamp the request to occupancy and to the port width.
    always_comb begin : dequeue_calc
        w_dn = CNT_W'(dispatch_num);
        if (w_dn > CNT_W'(SUPERSCALAR_WAYS)) begin
            w_dn = CNT_W'(SUPERSCALAR_WAYS);
        end
        w_d = (w_dn < r_count) ? w_dn : r_count;
    end

    // Stall feedback: fetch resumes at the first way that was not accepted.
    always_comb begin : feedback
        dispatch_fetch_out                 = '0;
        dispatch_fetch_out.enable          = !w_block && (w_k < w_nvalid);
        if (dispatch_fetch_out.enable) begin
            dispatch_fetch_out.first_stall_idx = IDX_W'(w_k);
        end
    end

    // Head window; valids are masked while reset or flush is in effect.
    always_comb begin : out_view
        for (int i = 0; i < int'(SUPERSCALAR_WAYS); i++) begin
            ib_out[i]       = r_mem[r_head + PTR_W'(i)];
            ib_out[i].valid = !w_block && (CNT_W'(i) < r_count);
        end
    end

    assign ib_count = reset ? '0 : r_count;

    // Pointer/count/storage update; reset over flush over normal enqueue+dequeue.
    always_ff @(posedge clock) begin : state_update
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_mem   <= '0;
        end else if (branch_flush_en) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < int'(SUPERSCALAR_WAYS); i++) begin
                if (CNT_W'(i) < w_k) begin
                    r_mem[r_tail + PTR_W'(i)] <= fetch_dispatch_in[i];
                end
            end
            r_tail  <= r_tail + PTR_W'(w_k);
            r_head  <= r_head + PTR_W'(w_d);
            r_count <= r_count + w_k - w_d;
        end
    end

endmodule

// File: tb/tb_inst_buffer.sv
// Directed bench for inst_buffer with SUPERSCALAR_WAYS=2, IB_DEPTH=4.
module tb_inst_buffer;
    import inst_buffer_pkg::*;

    localparam int unsigned W = 2;
    localparam int unsigned D = 4;
    localparam int unsigned NV = 17;

    logic                 clock;
    logic                 reset;
    logic                 branch_flush_en;
    FETCH_DISPATCH_PACKET fd_in [W];
    logic [1:0]           dispatch_num;
    DISPATCH_FETCH_PACKET df_out;
    FETCH_DISPATCH_PACKET ib_out [W];
    logic [2:0]           ib_count;

    int n_checks;
    int n_fail;

    inst_buffer #(.SUPERSCALAR_WAYS(W), .IB_DEPTH(D)) dut (
        .clock              (clock),
        .reset              (reset),
        .branch_flush_en    (branch_flush_en),
        .fetch_dispatch_in  (fd_in),
        .dispatch_num       (dispatch_num),
        .dispatch_fetch_out (df_out),
        .ib_out             (ib_out),
        .ib_count           (ib_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int unsigned rst, flush, v0, v1, pc0, pc1, dnum;  // inputs
        int unsigned en, idx;                             // same-cycle feedback
        int unsigned cnt, ov0, ov1, opc0, opc1;           // state after the edge
    } vec_t;

    vec_t vecs [NV];

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return {pc[15:0], ~pc[15:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic drive_way(input int w, input int unsigned v, input int unsigned pc);
        fd_in[w].valid = 1'(v);
        fd_in[w].PC    = pc;
        fd_in[w].NPC   = pc + 32'd4;
        fd_in[w].inst  = inst_of(pc);
    endtask

    task automatic idle();
        reset           = 1'b0;
        branch_flush_en = 1'b0;
        dispatch_num    = 2'd0;
        drive_way(0, 0, 0);
        drive_way(1, 0, 0);
    endtask

    task automatic check_slot(input string tag, input int w, input int unsigned ev, input int unsigned epc);
        chk($sformatf("%s.ib_out%0d.valid", tag, w), 32'(ib_out[w].valid), ev);
        if (ev != 0) begin
            chk($sformatf("%s.ib_out%0d.PC", tag, w), ib_out[w].PC, epc);
            chk($sformatf("%s.ib_out%0d.NPC", tag, w), ib_out[w].NPC, epc + 4);
            chk($sformatf("%s.ib_out%0d.inst", tag, w), ib_out[w].inst, inst_of(epc));
        end
    endtask

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int unsigned send_pc;
        int unsigned exp_pc;
        int unsigned got;
        int unsigned mcount;
        int unsigned acc;
        int unsigned dn;
        int unsigned d;
        string tag;

        n_checks = 0;
        n_fail   = 0;
        idle();
        reset = 1'b1;

        //            rst fl v0 v1 pc0    pc1    dn  en idx cnt ov0 ov1 opc0   opc1
        vecs[0]  = '{1, 0, 1, 1, 'h100, 'h104, 0,  0, 0,  0,  0,  0,  0,     0};
        vecs[1]  = '{0, 0, 1, 1, 'h0,   'h4,   0,  0, 0,  2,  1,  1,  'h0,   'h4};
        vecs[2]  = '{0, 0, 1, 0, 'h8,   'h0,   0,  0, 0,  3,  1,  1,  'h0,   'h4};
        vecs[3]  = '{0, 0, 1, 1, 'hC,   'h10,  0,  1, 1,  4,  1,  1,  'h0,   'h4};
        vecs[4]  = '{0, 0, 1, 1, 'h14,  'h18,  0,  1, 0,  4,  1,  1,  'h0,   'h4};
        vecs[5]  = '{0, 0, 0, 0, 'h0,   'h0,   2,  0, 0,  2,  1,  1,  'h8,   'hC};
        vecs[6]  = '{0, 0, 1, 1, 'h10,  'h14,  1,  0, 0,  3,  1,  1,  'hC,   'h10};
        vecs[7]  = '{0, 0, 0, 0, 'h0,   'h0,   2,  0, 0,  1,  1,  0,  'h14,  0};
        vecs[8]  = '{0, 0, 0, 0, 'h0,   'h0,   2,  0, 0,  0,  0,  0,  0,     0};
        vecs[9]  = '{0, 0, 1, 1, 'h18,  'h1C,  0,  0, 0,  2,  1,  1,  'h18,  'h1C};
        vecs[10] = '{0, 0, 1, 0, 'h20,  'h0,   0,  0, 0,  3,  1,  1,  'h18,  'h1C};
        vecs[11] = '{0, 1, 1, 1, 'h24,  'h28,  2,  0, 0,  0,  0,  0,  0,     0};
        vecs[12] = '{0, 0, 1, 1, 'h30,  'h34,  0,  0, 0,  2,  1,  1,  'h30,  'h34};
        vecs[13] = '{0, 0, 1, 0, 'h38,  'h0,   0,  0, 0,  3,  1,  1,  'h30,  'h34};
        vecs[14] = '{1, 0, 1, 1, 'h40,  'h44,  1,  0, 0,  0,  0,  0,  0,     0};
        vecs[15] = '{0, 0, 1, 1, 'h50,  'h54,  0,  0, 0,  2,  1,  1,  'h50,  'h54};
        vecs[16] = '{0, 0, 0, 1, 'h0,   'h58,  0,  1, 0,  2,  1,  1,  'h50,  'h54};

        for (int i = 0; i < int'(NV); i++) begin
            tag = $sformatf("v%0d", i);
            @(negedge clock);
            reset           = 1'(vecs[i].rst);
            branch_flush_en = 1'(vecs[i].flush);
            dispatch_num    = 2'(vecs[i].dnum);
            drive_way(0, vecs[i].v0, vecs[i].pc0);
            drive_way(1, vecs[i].v1, vecs[i].pc1);
            #1;
            chk({tag, ".enable"}, 32'(df_out.enable), vecs[i].en);
            chk({tag, ".first_stall_idx"}, 32'(df_out.first_stall_idx), vecs[i].idx);
            if (vecs[i].rst != 0 || vecs[i].flush != 0) begin
                chk({tag, ".pre.valid0"}, 32'(ib_out[0].valid), 0);
                chk({tag, ".pre.valid1"}, 32'(ib_out[1].valid), 0);
            end
            if (vecs[i].rst != 0) begin
                chk({tag, ".pre.ib_count"}, 32'(ib_count), 0);
            end
            @(posedge clock);
            #1;
            idle();
            #1;
            chk({tag, ".ib_count"}, 32'(ib_count), vecs[i].cnt);
            check_slot(tag, 0, vecs[i].ov0, vecs[i].opc0);
            check_slot(tag, 1, vecs[i].ov1, vecs[i].opc1);
        end

        // Streaming across several pointer wraps; dispatch takes 2 every cycle after the first.
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        idle();
        send_pc = 0;
        exp_pc  = 0;
        got     = 0;
        mcount  = 0;
        for (int cyc = 0; cyc < 40 && got < 16; cyc++) begin
            @(negedge clock);
            acc = 0;
            if (send_pc < 'h40) begin
                drive_way(0, 1, send_pc);
                drive_way(1, 1, send_pc + 4);
                acc = 2;
            end else begin
                drive_way(0, 0, 0);
                drive_way(1, 0, 0);
            end
            dn = (cyc > 0) ? 2 : 0;
            dispatch_num = 2'(dn);
            #1;
            chk($sformatf("wrap.c%0d.enable", cyc), 32'(df_out.enable), 0);
            d = (dn < mcount) ? dn : mcount;
            for (int i = 0; i < int'(dn); i++) begin
                chk($sformatf("wrap.c%0d.valid%0d", cyc, i), 32'(ib_out[i].valid), (i < int'(mcount)) ? 1 : 0);
                if (i < int'(mcount)) begin
                    chk($sformatf("wrap.c%0d.PC%0d", cyc, i), ib_out[i].PC, exp_pc);
                    exp_pc = exp_pc + 4;
                    got    = got + 1;
                end
            end
            mcount  = mcount + acc - d;
            send_pc = send_pc + 4 * acc;
            @(posedge clock);
            #1;
        end
        chk("wrap.consumed", got, 16);
        idle();
        #1;
        chk("wrap.final_count", 32'(ib_count), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
